// File: rtl/regfile_responder_pkg.sv
// ============================================================================
// Module : regfile_responder_pkg
// Brief  : Shared constants and state encoding for the register-file responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_responder_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_ADDR_W  = 5;
    localparam int c_STATE_W = 1;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : regfile_responder_pkg

`default_nettype wire

// File: rtl/regfile_responder_if.sv
// ============================================================================
// Module : regfile_responder_if
// Brief  : Request/response handshake bundle between a requester and the responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface regfile_responder_if
    import regfile_responder_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addrA;
    logic [ADDR_W-1:0] req_addrB;
    logic [DATA_W-1:0] req_data;
    logic              clear_start;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_write;
    logic [DATA_W-1:0] resp_dataA;
    logic [DATA_W-1:0] resp_dataB;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addrA, req_addrB, req_data,
               clear_start, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_dataA, resp_dataB, busy
    );

    modport slave (
        input  req_valid, req_write, req_addrA, req_addrB, req_data,
               clear_start, resp_ready,
        output req_ready, resp_valid, resp_write, resp_dataA, resp_dataB, busy
    );

endinterface : regfile_responder_if

`default_nettype wire

// File: rtl/regfile_array.sv
// ============================================================================
// Module : regfile_array
// Brief  : Register storage, one write port (clear sweep wins) and two async reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_array
    import regfile_responder_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int ZERO_REG0 = 1
) (
    input  wire logic              clock,
    input  wire logic              ctrl_reset,
    input  wire logic              i_reqWe,
    input  wire logic [ADDR_W-1:0] i_reqAddr,
    input  wire logic [DATA_W-1:0] i_reqData,
    input  wire logic              i_clrWe,
    input  wire logic [ADDR_W-1:0] i_clrAddr,
    input  wire logic [ADDR_W-1:0] i_rdAddrA,
    input  wire logic [ADDR_W-1:0] i_rdAddrB,
    output logic      [DATA_W-1:0] o_rdDataA,
    output logic      [DATA_W-1:0] o_rdDataB
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic              w_we;
    logic [ADDR_W-1:0] w_wAddr;
    logic [DATA_W-1:0] w_wData;
    logic [DATA_W-1:0] w_regs [c_DEPTH];

    always_comb begin
        w_we    = i_clrWe | i_reqWe;
        w_wAddr = i_clrWe ? i_clrAddr : i_reqAddr;
        w_wData = i_clrWe ? '0 : i_reqData;
    end

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_reg
        if (ZERO_REG0 != 0 && gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clock or negedge ctrl_reset) begin
                if (!ctrl_reset) begin
                    r_q <= '0;
                end else if (w_we && (w_wAddr == ADDR_W'(gi))) begin
                    r_q <= w_wData;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    assign o_rdDataA = w_regs[i_rdAddrA];
    assign o_rdDataB = w_regs[i_rdAddrB];

endmodule : regfile_array

`default_nettype wire

// File: rtl/regfile_responder.sv
// ============================================================================
// Module : regfile_responder
// Brief  : Latency-1 register-file request/response engine with a clear sweep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_responder
    import regfile_responder_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int ZERO_REG0 = 1
) (
    input wire logic      clock,
    input wire logic      ctrl_reset,
    regfile_responder_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrIdx;
    logic [ADDR_W-1:0] w_nextClrIdx;
    logic              w_clrWe;
    logic              w_respFree;
    logic              w_reqReady;
    logic              w_accept;
    logic              r_respValid;
    logic              r_respWrite;
    logic [DATA_W-1:0] r_respDataA;
    logic [DATA_W-1:0] r_respDataB;
    logic [DATA_W-1:0] w_rdDataA;
    logic [DATA_W-1:0] w_rdDataB;

    always_comb begin
        w_nextState  = r_state;
        w_nextClrIdx = r_clrIdx;
        w_clrWe      = 1'b0;
        w_reqReady   = 1'b0;
        w_accept     = 1'b0;
        w_respFree   = !r_respValid || bus.resp_ready;
        case (r_state)
            IDLE: begin
                // clear_start outranks a same-cycle request
                w_reqReady = ctrl_reset && w_respFree && !bus.clear_start;
                w_accept   = w_reqReady && bus.req_valid;
                if (bus.clear_start && w_respFree) begin
                    w_nextState  = CLEAR;
                    w_nextClrIdx = '0;
                end
            end
            CLEAR: begin
                w_clrWe = 1'b1;
                if (r_clrIdx == c_LAST_IDX) begin
                    w_nextState  = IDLE;
                    w_nextClrIdx = '0;
                end else begin
                    w_nextClrIdx = r_clrIdx + ADDR_W'(1);
                end
            end
            default: begin
                w_nextState  = IDLE;
                w_nextClrIdx = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state  <= IDLE;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_nextState;
            r_clrIdx <= w_nextClrIdx;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_respValid <= 1'b0;
            r_respWrite <= 1'b0;
            r_respDataA <= '0;
            r_respDataB <= '0;
        end else if (w_accept) begin
            r_respValid <= 1'b1;
            r_respWrite <= bus.req_write;
            r_respDataA <= bus.req_write ? bus.req_data : w_rdDataA;
            r_respDataB <= bus.req_write ? '0 : w_rdDataB;
        end else if (bus.resp_ready) begin
            r_respValid <= 1'b0;
        end
    end

    regfile_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ZERO_REG0 (ZERO_REG0)
    ) u_array (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .i_reqWe    (w_accept && bus.req_write),
        .i_reqAddr  (bus.req_addrA),
        .i_reqData  (bus.req_data),
        .i_clrWe    (w_clrWe),
        .i_clrAddr  (r_clrIdx),
        .i_rdAddrA  (bus.req_addrA),
        .i_rdAddrB  (bus.req_addrB),
        .o_rdDataA  (w_rdDataA),
        .o_rdDataB  (w_rdDataB)
    );

    assign bus.req_ready  = w_reqReady;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_write = r_respWrite;
    assign bus.resp_dataA = r_respDataA;
    assign bus.resp_dataB = r_respDataB;
    assign bus.busy       = (r_state == CLEAR);

endmodule : regfile_responder

`default_nettype wire

// File: doc/regfile_responder.md
REGFILE_RESPONDER -- requirements
Module: regfile_responder

Interface
REQ-001 Parameter DATA_W, default 32, register and data width.
REQ-002 Parameter ADDR_W, default 5, address width; depth is 2**ADDR_W (32 at default).
REQ-003 Parameter ZERO_REG0, default 1, when 1 register 0 reads 0 and writes to it are discarded.
REQ-004 clock  input  1  single clock for the block; all state on rising edge.
REQ-005 ctrl_reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-008 req_write  input  1  1 = write request, 0 = dual read request.
REQ-009 req_addrA  input  ADDR_W  write address (write) or port-A read address (read).
REQ-010 req_addrB  input  ADDR_W  port-B read address; ignored on write.
REQ-011 req_data  input  DATA_W  write data; ignored on read.
REQ-012 clear_start  input  1  request a full-array clear sweep.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  response consumed when resp_valid and resp_ready are both 1 at a rising edge.
REQ-015 resp_write  output  1  1 = response is a write acknowledge, 0 = read data.
REQ-016 resp_dataA  output  DATA_W  read data A, or echoed write data on a write acknowledge.
REQ-017 resp_dataB  output  DATA_W  read data B; 0 on a write acknowledge.
REQ-018 busy  output  1  1 while a clear sweep is in progress.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR.
REQ-020 In IDLE, req_ready SHALL be (!resp_valid || resp_ready), combinational.
- This gives a throughput of one request per cycle under no backpressure.
REQ-021 An accepted request SHALL produce resp_valid=1 in the next cycle (latency 1), with the response fields registered.
REQ-022 An accepted write SHALL update the addressed register at the accepting edge.
- Exception: when ZERO_REG0=1 and req_addrA=0, the write is discarded.
- The write SHALL still be acknowledged with resp_write=1 and resp_dataA=req_data.
REQ-023 An accepted read SHALL return the register contents as of the accepting edge, before any same-edge write.
- No same-edge write can occur, since only one request is accepted per cycle.
- A read accepted the cycle after a write SHALL return the new value.
REQ-024 A response held with resp_ready=0 SHALL keep all resp_* outputs stable until it is consumed.
REQ-025 resp_valid SHALL deassert the cycle after consumption unless a new request was accepted on the same edge.
REQ-026 clear_start SHALL be honoured only in IDLE with no response pending (resp_valid=0 or consumed on that edge).
- clear_start has priority over req_valid in the same cycle; the request is not accepted (req_ready=0 that cycle).
REQ-027 The CLEAR state SHALL behave as follows:
- Zero one register per cycle, index 0 to 2**ADDR_W-1 (32 cycles at default).
- Hold req_ready=0 and busy=1 throughout.
- Return to IDLE after the last index.
- clear_start while busy is ignored.
REQ-028 The clear index counter SHALL be ADDR_W bits and terminate on the all-ones value, not by wrap-around.

Reset
REQ-029 While ctrl_reset=0:
- All registers are 0, the state is IDLE and the clear index is 0.
- resp_valid, resp_write, resp_dataA, resp_dataB and busy are 0.
- req_ready is 0.
REQ-030 A reset asserted mid-sweep or with a response pending SHALL abort it immediately; no response is delivered afterwards.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, CLEAR) and the default DATA_W and ADDR_W constants.
REQ-032 Storage SHALL be one sub-module, regfile_array, containing:
- one write port, written by either a request or the clear sweep, with the sweep having priority;
- two asynchronous read ports.
The control FSM and response register SHALL remain in regfile_responder.

Verification
REQ-033 Scenario: reset, then write 32'h0000DEAD to each of registers 1..31 and read each back on A and B -> every read returns 32'h0000DEAD on both ports.
REQ-034 Scenario: with ZERO_REG0=1, write 32'h0000DEAD to register 0, then read 0 -> resp_write=1 with resp_dataA=32'h0000DEAD on the acknowledge, then read data 0 on both ports.
REQ-035 Scenario: back-to-back write reg5=32'hCAFE0001, then read A=5 B=5 on the next cycle, resp_ready=1 throughout -> resp_valid stays high 2 cycles; the second response returns 32'hCAFE0001 on both ports.
REQ-036 Scenario: hold resp_ready=0 for 4 cycles with a read response pending and req_valid=1 -> req_ready=0 and resp_* stable; after resp_ready=1 the next request is accepted on that same edge.
REQ-037 Scenario: fill registers with nonzero data, pulse clear_start with req_valid=1 in the same cycle -> request not accepted, busy=1 for 32 cycles, then all reads return 0.
REQ-038 Scenario: assert ctrl_reset=0 at clear index 10, then release -> busy=0 and resp_valid=0 immediately, all registers read 0, and a subsequent write then read works.
